sorter_oet: RTL and testbench

- Parametrised iterative sorter of N unsigned W-bit elements using odd-even transposition.
- Successor to the fixed 8x8 combinational sorter. Trades latency for area: one compare-exchange rank per cycle instead of a full unrolled network.
- Adds a valid/ready handshake on both sides, a per-job ascending/descending mode, a stall enable, and asynchronous reset.
- Sits between a packed-vector producer and consumer in the comparator datapath.

---
 rtl/sorter_pkg.sv | 17 +
 rtl/sort_cx.sv | 19 +
 rtl/sorter_oet.sv | 134 +++++++++++++
 tb/tb_sorter_oet.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the iterative odd-even transposition sorter.
package sorter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Phase counter width: clog2(n), never less than one bit.
    function automatic int unsigned phase_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sort_cx.sv
// Combinational compare-exchange cell; lo_idx_out lands at the lower array index.
module sort_cx #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo_idx_out,
    output logic [W-1:0] hi_idx_out
);

    logic swap_c;

    // Strict compares so equal values never swap.
    assign swap_c     = desc ? (a < b) : (a > b);
    assign lo_idx_out = swap_c ? b : a;
    assign hi_idx_out = swap_c ? a : b;

endmodule

// File: rtl/sorter_oet.sv
// Iterative odd-even transposition sorter: one compare-exchange rank per enabled cycle,
// with valid/ready handshakes on input and output.
module sorter_oet
    import sorter_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           in_desc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           busy
);

    localparam int unsigned PW    = phase_w(N);
    localparam int unsigned NE    = N / 2;
    localparam int unsigned NO    = (N - 1) / 2;
    localparam int unsigned LAST  = N - 1;

    state_e          state_q, state_d;
    logic [N*W-1:0]  data_q, data_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            desc_q, desc_d;

    logic [N*W-1:0]  even_arr_c;
    logic [N*W-1:0]  odd_arr_c;
    logic            accept_c;
    logic            phase_last_c;

    assign accept_c     = in_valid && in_ready;
    assign phase_last_c = (phase_q == PW'(LAST));

    // Even rank: pairs (0,1), (2,3), ...; a trailing element passes through for odd N.
    for (genvar k = 0; k < NE; k++) begin : g_even
        sort_cx #(.W(W)) u_cx (
            .a          (data_q[(2*k)*W +: W]),
            .b          (data_q[(2*k+1)*W +: W]),
            .desc       (desc_q),
            .lo_idx_out (even_arr_c[(2*k)*W +: W]),
            .hi_idx_out (even_arr_c[(2*k+1)*W +: W])
        );
    end
    if (N % 2 == 1) begin : g_even_tail
        assign even_arr_c[(N-1)*W +: W] = data_q[(N-1)*W +: W];
    end

    // Odd rank: pairs (1,2), (3,4), ...; element 0 always passes, the last one too for even N.
    for (genvar k = 0; k < NO; k++) begin : g_odd
        sort_cx #(.W(W)) u_cx (
            .a          (data_q[(2*k+1)*W +: W]),
            .b          (data_q[(2*k+2)*W +: W]),
            .desc       (desc_q),
            .lo_idx_out (odd_arr_c[(2*k+1)*W +: W]),
            .hi_idx_out (odd_arr_c[(2*k+2)*W +: W])
        );
    end
    assign odd_arr_c[0 +: W] = data_q[0 +: W];
    if (N % 2 == 0) begin : g_odd_tail
        assign odd_arr_c[(N-1)*W +: W] = data_q[(N-1)*W +: W];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept_c)                state_d = ST_SORT;
            ST_SORT: if (enable && phase_last_c)  state_d = ST_DONE;
            ST_DONE: if (out_ready)               state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; in_ready is also held low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: in_ready = !rst;
            ST_SORT: busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Datapath next state: load on accept, one rank per enabled SORT cycle.
    always_comb begin
        data_d  = data_q;
        phase_d = phase_q;
        desc_d  = desc_q;
        if (accept_c) begin
            data_d  = in_data;
            phase_d = '0;
            desc_d  = in_desc;
        end else if ((state_q == ST_SORT) && enable) begin
            data_d  = phase_q[0] ? odd_arr_c : even_arr_c;
            phase_d = phase_last_c ? phase_q : phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            phase_q <= '0;
            desc_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            phase_q <= phase_d;
            desc_q  <= desc_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_sorter_oet.sv
// Directed self-checking bench for sorter_oet at N=8, W=8.
module tb_sorter_oet;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 8;
    localparam int unsigned DW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_desc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int total = 0;
    int bad   = 0;

    sorter_oet #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present a job and return #1 after the edge that accepts it.
    task automatic start_job(input logic [DW-1:0] d, input logic dsc);
        int n;
        n = 0;
        in_data  = d;
        in_desc  = dsc;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_job_ready: in_ready=%b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_data: got=%h want=0", out_data); end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got=%b want=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got=%b want=1", in_ready); end
    endtask

    task automatic test_descending();
        int lat;
        start_job(64'h0807060504030201, 1'b1);
        wait_done(lat);
        total++;
        if (lat != 8) begin bad++; $display("FAIL desc_latency: got=%0d want=8", lat); end
        total++;
        if (out_data !== 64'h0102030405060708) begin
            bad++; $display("FAIL desc_data: got=%h want=0102030405060708", out_data);
        end
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL desc_done_flags: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        release_out();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL desc_handshake: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                            out_valid, in_ready, busy);
        end
        total++;
        if (out_data !== 64'h0102030405060708) begin
            bad++; $display("FAIL desc_idle_hold: got=%h want=0102030405060708", out_data);
        end
    endtask

    task automatic test_ascending();
        int lat;
        start_job(64'h0807060504030201, 1'b0);
        wait_done(lat);
        total++;
        if (lat != 8) begin bad++; $display("FAIL asc_latency: got=%0d want=8", lat); end
        total++;
        if (out_data !== 64'h0807060504030201) begin
            bad++; $display("FAIL asc_data: got=%h want=0807060504030201", out_data);
        end
        release_out();
    endtask

    task automatic test_extremes();
        int lat;
        start_job(64'hFF00FF0000FF7F80, 1'b1);
        wait_done(lat);
        total++;
        if (out_data !== 64'h0000007F80FFFFFF) begin
            bad++; $display("FAIL dup_data: got=%h want=0000007F80FFFFFF", out_data);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        start_job(64'h0807060504030201, 1'b1);
        wait_done(lat);
        in_data  = 64'h1122334455667788;
        in_desc  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'h0102030405060708) begin
                bad++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h want 1/0/0102030405060708",
                                i, out_valid, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out_data !== 64'h1122334455667788) begin
            bad++; $display("FAIL bp_load: busy=%b data=%h want 1/1122334455667788", busy, out_data);
        end
        wait_done(lat);
        total++;
        if (lat != 8 || out_data !== 64'h8877665544332211) begin
            bad++; $display("FAIL bp_new_job: lat=%0d data=%h want 8/8877665544332211", lat, out_data);
        end
        release_out();
    endtask

    task automatic test_stall();
        int lat;
        start_job(64'h0807060504030201, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (out_data !== 64'h0507030801060204) begin
            bad++; $display("FAIL stall_phase2: got=%h want=0507030801060204", out_data);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_data !== 64'h0507030801060204 || out_valid !== 1'b0) begin
                bad++; $display("FAIL stall_freeze[%0d]: data=%h out_valid=%b want 0507030801060204/0",
                                i, out_data, out_valid);
            end
        end
        enable = 1'b1;
        wait_done(lat);
        lat += 6;
        total++;
        if (lat != 11) begin bad++; $display("FAIL stall_latency: got=%0d want=11", lat); end
        total++;
        if (out_data !== 64'h0102030405060708) begin
            bad++; $display("FAIL stall_data: got=%h want=0102030405060708", out_data);
        end
        release_out();
    endtask

    task automatic test_reset_midjob();
        int lat;
        start_job(64'h0807060504030201, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_data !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midjob_reset: data=%h busy=%b out_valid=%b in_ready=%b want 0/0/0/0",
                            out_data, busy, out_valid, in_ready);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
            bad++; $display("FAIL midjob_after: in_ready=%b busy=%b data=%h want 1/0/0",
                            in_ready, busy, out_data);
        end
        start_job(64'hFF00FF0000FF7F80, 1'b1);
        wait_done(lat);
        total++;
        if (lat != 8 || out_data !== 64'h0000007F80FFFFFF) begin
            bad++; $display("FAIL midjob_fresh: lat=%0d data=%h want 8/0000007F80FFFFFF", lat, out_data);
        end
        release_out();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_desc   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_descending();
        test_ascending();
        test_extremes();
        test_backpressure();
        test_stall();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
